// File: rtl/vga_timing_controller_pkg.sv
// Shared widths, default 640x480@60 timing and a window-compare helper for
// the VGA timing controller.
package vga_timing_controller_pkg;

  localparam int CNT_W   = 10;  // h/v counter width
  localparam int COORD_W = 12;  // x/y coordinate width seen by the image generator
  localparam int RGB_W   = 3;   // one bit each for R, G, B

  // Visible frame size as the game logic sees it
  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
  localparam int   DEF_H_VISIBLE   = FRAME_WIDTH;
  localparam int   DEF_H_FRONT     = 16;
  localparam int   DEF_H_SYNC      = 96;
  localparam int   DEF_H_BACK      = 48;
  localparam int   DEF_V_VISIBLE   = FRAME_HEIGHT;
  localparam int   DEF_V_FRONT     = 10;
  localparam int   DEF_V_SYNC      = 2;
  localparam int   DEF_V_BACK      = 33;
  localparam logic DEF_SYNC_ACTIVE = 1'b0;

  // True when lo <= val < hi
  function automatic logic in_window(input logic [CNT_W-1:0] val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Pixel-side and connector-side signals of the VGA timing controller.
// The controller is the master; the image generator / pins side is the slave.
interface vga_timing_controller_if;
  import vga_timing_controller_pkg::*;

  logic [RGB_W-1:0]   color;        // from image generator, for current x,y
  logic [COORD_W-1:0] x;            // 1-based column, 0 in blanking
  logic [COORD_W-1:0] y;            // 1-based row, 0 in blanking
  logic [RGB_W-1:0]   vga_rgb;
  logic               vga_hsync;
  logic               vga_vsync;
  logic               vga_blank_n;
  logic               frame_tick;

  modport master (
    input  color,
    output x, y, vga_rgb, vga_hsync, vga_vsync, vga_blank_n, frame_tick
  );

  modport slave (
    output color,
    input  x, y, vga_rgb, vga_hsync, vga_vsync, vga_blank_n, frame_tick
  );
endinterface

// File: rtl/vga_timing_controller_mod_counter.sv
// Modulo-N counter with enable, a combinational wrap pulse and
// asynchronous active-low reset.
module mod_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);
  logic [W-1:0] r_count;

  // Wrap is only meaningful on a cycle where the counter actually advances
  assign o_wrap  = i_en && (r_count == W'(N - 1));
  assign o_count = r_count;

  // Count 0..N-1 while enabled, returning to 0 after N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing controller: horizontal/vertical raster counters, 1-based pixel
// coordinates for the image generator, and one registered output stage that
// drives RGB, syncs, blank and a once-per-frame tick.
module vga_timing_controller
  import vga_timing_controller_pkg::*;
#(
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic                    CLOCK_25,
  input  logic                    RESET_N,
  vga_timing_controller_if.master bus
);
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_visible;
  logic             w_h_sync_on;
  logic             w_v_sync_on;
  logic             w_frame_end;

  logic [RGB_W-1:0] r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank_n;
  logic             r_frame_tick;

  // Pixel counter runs every clock; line counter advances on pixel wrap
  mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_counter (
    .clk     (CLOCK_25),
    .rst_n   (RESET_N),
    .i_en    (1'b1),
    .o_count (w_h_cnt),
    .o_wrap  (w_h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_counter (
    .clk     (CLOCK_25),
    .rst_n   (RESET_N),
    .i_en    (w_h_wrap),
    .o_count (w_v_cnt),
    .o_wrap  (w_v_wrap)
  );

  // The frame can only end on the last pixel of a line
  a_frame_wrap_on_line_end : assert property (
    @(posedge CLOCK_25) disable iff (!RESET_N) w_v_wrap |-> w_h_wrap);

  assign w_visible   = (int'(w_h_cnt) < H_VISIBLE) && (int'(w_v_cnt) < V_VISIBLE);
  assign w_h_sync_on = in_window(w_h_cnt, H_SYNC_START, H_SYNC_END);
  assign w_v_sync_on = in_window(w_v_cnt, V_SYNC_START, V_SYNC_END);
  assign w_frame_end = (int'(w_h_cnt) == H_TOTAL - 1) && (int'(w_v_cnt) == V_VISIBLE - 1);

  // Coordinates are 1-based so the game's border sits at x==1 / x==FRAME_WIDTH
  assign bus.x = w_visible ? (COORD_W'(w_h_cnt) + COORD_W'(1)) : '0;
  assign bus.y = w_visible ? (COORD_W'(w_v_cnt) + COORD_W'(1)) : '0;

  // Single output register stage; all connector outputs share one cycle of latency
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rgb        <= '0;
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_blank_n    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_rgb        <= w_visible ? bus.color : '0;
      r_hsync      <= w_h_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync      <= w_v_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_blank_n    <= w_visible;
      r_frame_tick <= w_frame_end;
    end
  end

  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hsync   = r_hsync;
  assign bus.vga_vsync   = r_vsync;
  assign bus.vga_blank_n = r_blank_n;
  assign bus.frame_tick  = r_frame_tick;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: one full 640x480 instance (line-level
// timing) and one shrunken-timing instance (frame-level timing), each checked
// every cycle against a raster model plus directed literal expectations.
module tb_vga_timing_controller;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tim_t;

  typedef struct {
    int x, y, rgb, hsync, vsync, blank_n, tick;
  } exp_t;

  localparam tim_t FULL_T  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam tim_t SMALL_T = '{16, 2, 4, 3, 6, 1, 2, 2};

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_f;
  logic rst_s;
  int   mode_f;
  int   mode_s;
  int   k_f;    // rising edges since full instance left reset
  int   k_s;    // rising edges since small instance left reset
  int   n_checks = 0;
  int   n_pass   = 0;

  vga_timing_controller_if bus_f();
  vga_timing_controller_if bus_s();

  vga_timing_controller u_full (
    .CLOCK_25 (clk),
    .RESET_N  (rst_f),
    .bus      (bus_f)
  );

  vga_timing_controller #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .CLOCK_25 (clk),
    .RESET_N  (rst_s),
    .bus      (bus_s)
  );

  // Image generator stand-in: 1 = constant white, 2 = blue only in column 1, else a pattern
  function automatic int colfn(input int mode, input int x, input int y);
    case (mode)
      1:       return 7;
      2:       return (x == 1) ? 1 : 0;
      default: return (x + 2 * y) % 8;
    endcase
  endfunction

  assign bus_f.color = 3'(colfn(mode_f, int'(bus_f.x), int'(bus_f.y)));
  assign bus_s.color = 3'(colfn(mode_s, int'(bus_s.x), int'(bus_s.y)));

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) k_f <= 0;
    else        k_f <= k_f + 1;
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) k_s <= 0;
    else        k_s <= k_s + 1;
  end

  // Raster model: after k edges the beam sits at pixel k of the frame sequence;
  // registered outputs describe pixel k-1, coordinates describe pixel k.
  function automatic exp_t model(input tim_t t, input int k, input int mode);
    exp_t e;
    int ht, vt, col, row, pcol, prow;
    bit vis, pvis;
    ht  = t.hv + t.hf + t.hs + t.hb;
    vt  = t.vv + t.vf + t.vs + t.vb;
    col = k % ht;
    row = (k / ht) % vt;
    vis = (col < t.hv) && (row < t.vv);
    e.x = vis ? col + 1 : 0;
    e.y = vis ? row + 1 : 0;
    if (k == 0) begin
      e.rgb = 0; e.hsync = 1; e.vsync = 1; e.blank_n = 0; e.tick = 0;
    end else begin
      pcol      = (k - 1) % ht;
      prow      = ((k - 1) / ht) % vt;
      pvis      = (pcol < t.hv) && (prow < t.vv);
      e.rgb     = pvis ? colfn(mode, pcol + 1, prow + 1) : 0;
      e.hsync   = (pcol >= t.hv + t.hf && pcol < t.hv + t.hf + t.hs) ? 0 : 1;
      e.vsync   = (prow >= t.vv + t.vf && prow < t.vv + t.vf + t.vs) ? 0 : 1;
      e.blank_n = pvis ? 1 : 0;
      e.tick    = (pcol == ht - 1 && prow == t.vv - 1) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic cmp(input string tag, input tim_t t, input int k, input int mode,
                     input int x, input int y, input int rgb, input int hs,
                     input int vs, input int bn, input int tk);
    exp_t e;
    e = model(t, k, mode);
    chk({tag, ".x"}, x, e.x);
    chk({tag, ".y"}, y, e.y);
    chk({tag, ".rgb"}, rgb, e.rgb);
    chk({tag, ".hsync"}, hs, e.hsync);
    chk({tag, ".vsync"}, vs, e.vsync);
    chk({tag, ".blank_n"}, bn, e.blank_n);
    chk({tag, ".frame_tick"}, tk, e.tick);
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    cmp("full", FULL_T, k_f, mode_f, int'(bus_f.x), int'(bus_f.y), int'(bus_f.vga_rgb),
        int'(bus_f.vga_hsync), int'(bus_f.vga_vsync), int'(bus_f.vga_blank_n),
        int'(bus_f.frame_tick));
    cmp("small", SMALL_T, k_s, mode_s, int'(bus_s.x), int'(bus_s.y), int'(bus_s.vga_rgb),
        int'(bus_s.vga_hsync), int'(bus_s.vga_vsync), int'(bus_s.vga_blank_n),
        int'(bus_s.frame_tick));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int f_fall1, f_fall2, f_hlow, f_rgb1, f_rgb1_first, f_blank_first;
    int s_t1, s_t2, s_ticks, s_vfall, s_vlow, s_rgb7, s_blank, s_rgb_blank;
    int r_fall, r_blank, r_tick;
    bit prev_hs_f, prev_vs_s, prev_hs_s, found;

    f_fall1 = -1; f_fall2 = -1; f_hlow = 0; f_rgb1 = 0; f_rgb1_first = -1; f_blank_first = -1;
    s_t1 = -1; s_t2 = -1; s_ticks = 0; s_vfall = -1; s_vlow = 0; s_rgb7 = 0; s_blank = 0;
    s_rgb_blank = 0;

    rst_f = 1'b0; rst_s = 1'b0; mode_f = 2; mode_s = 1;
    repeat (3) step();
    chk("reset_x", int'(bus_f.x), 1);
    chk("reset_y", int'(bus_f.y), 1);
    chk("reset_hsync", int'(bus_f.vga_hsync), 1);
    chk("reset_vsync", int'(bus_f.vga_vsync), 1);
    chk("reset_blank_n", int'(bus_f.vga_blank_n), 0);
    chk("reset_rgb", int'(bus_f.vga_rgb), 0);
    chk("reset_tick", int'(bus_f.frame_tick), 0);
    $display("phase: reset checked, releasing both instances");

    rst_f = 1'b1; rst_s = 1'b1;
    prev_hs_f = 1'b1; prev_vs_s = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      step();
      if (!bus_f.vga_hsync && prev_hs_f) begin
        if (f_fall1 < 0) f_fall1 = c;
        else if (f_fall2 < 0) f_fall2 = c;
      end
      prev_hs_f = bus_f.vga_hsync;
      if (c <= 800 && !bus_f.vga_hsync) f_hlow++;
      if (bus_f.vga_rgb == 3'b001) begin
        f_rgb1++;
        if (f_rgb1_first < 0) f_rgb1_first = c;
      end
      if (bus_f.vga_blank_n && f_blank_first < 0) f_blank_first = c;

      if (bus_s.frame_tick) begin
        s_ticks++;
        if (s_t1 < 0) s_t1 = c;
        else if (s_t2 < 0) s_t2 = c;
      end
      if (!bus_s.vga_vsync && prev_vs_s && s_vfall < 0) s_vfall = c;
      prev_vs_s = bus_s.vga_vsync;
      if (c <= 275) begin
        if (!bus_s.vga_vsync) s_vlow++;
        if (bus_s.vga_rgb == 3'b111) s_rgb7++;
        if (bus_s.vga_blank_n) s_blank++;
      end
      if (!bus_s.vga_blank_n && bus_s.vga_rgb != 3'b000) s_rgb_blank++;
      if (c == 550) mode_s = 0;
    end
    $display("phase: free run done (full fall=%0d small tick=%0d)", f_fall1, s_t1);

    chk("full_first_hsync_fall", f_fall1, 657);
    chk("full_hsync_period", f_fall2 - f_fall1, 800);
    chk("full_hsync_low_width", f_hlow, 96);
    chk("full_first_blank_n", f_blank_first, 1);
    chk("full_col1_rgb_first", f_rgb1_first, 1);
    chk("full_col1_rgb_count", f_rgb1, 4);
    chk("small_first_tick", s_t1, 150);
    chk("small_tick_period", s_t2 - s_t1, 275);
    chk("small_tick_count", s_ticks, 11);
    chk("small_first_vsync_fall", s_vfall, 176);
    chk("small_vsync_low_width", s_vlow, 50);
    chk("small_white_cycles", s_rgb7, 96);
    chk("small_visible_cycles", s_blank, 96);
    chk("small_rgb_in_blank", s_rgb_blank, 0);

    // Mid-line reset of the full instance while hsync is asserted
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (k_f % 800 == 700) found = 1'b1;
      else step();
    end
    chk("full_reach_h700", int'(found), 1);
    chk("full_pre_reset_hsync", int'(bus_f.vga_hsync), 0);
    rst_f = 1'b0;
    #1;
    chk("full_async_hsync", int'(bus_f.vga_hsync), 1);
    chk("full_async_x", int'(bus_f.x), 1);
    chk("full_async_y", int'(bus_f.y), 1);
    chk("full_async_blank_n", int'(bus_f.vga_blank_n), 0);
    step();
    rst_f = 1'b1;
    r_fall = -1; r_blank = -1; prev_hs_f = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      step();
      if (!bus_f.vga_hsync && prev_hs_f && r_fall < 0) r_fall = c;
      prev_hs_f = bus_f.vga_hsync;
      if (bus_f.vga_blank_n && r_blank < 0) r_blank = c;
    end
    chk("full_rerun_hsync_fall", r_fall, 657);
    chk("full_rerun_blank_n", r_blank, 1);
    $display("phase: full mid-line reset done");

    // Reset of the small instance inside both sync pulses
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (k_s % 275 == 194) found = 1'b1;
      else step();
    end
    chk("small_reach_sync", int'(found), 1);
    chk("small_pre_reset_hsync", int'(bus_s.vga_hsync), 0);
    chk("small_pre_reset_vsync", int'(bus_s.vga_vsync), 0);
    rst_s = 1'b0;
    #1;
    chk("small_async_hsync", int'(bus_s.vga_hsync), 1);
    chk("small_async_vsync", int'(bus_s.vga_vsync), 1);
    chk("small_async_x", int'(bus_s.x), 1);
    chk("small_async_y", int'(bus_s.y), 1);
    chk("small_async_tick", int'(bus_s.frame_tick), 0);
    step();
    rst_s = 1'b1;
    r_fall = -1; r_tick = -1; prev_hs_s = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (!bus_s.vga_hsync && prev_hs_s && r_fall < 0) r_fall = c;
      prev_hs_s = bus_s.vga_hsync;
      if (bus_s.frame_tick && r_tick < 0) r_tick = c;
    end
    chk("small_rerun_hsync_fall", r_fall, 19);
    chk("small_rerun_tick", r_tick, 150);
    $display("phase: small in-sync reset done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
